out_arbiter: RTL and testbench

Round-robin arbiter that shares one router output channel among the five input-side transmitters (north, south, east, west, local). It drives the per-requester busy lines that gate each transmitter's enable, and captures the granted flit into a single-entry output register. The register is drained by a ready/valid handshake toward the link or local sink. One instance sits behind each of the five output ports of a router.

---
 rtl/out_arbiter_if.sv | 40 ++++
 rtl/out_arbiter.sv | 118 +++++++++++
 tb/tb_out_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/out_arbiter_if.sv
// Output-channel bundle between the five transmitters and one output arbiter.
//
// Handshakes:
// - Transmitter side: transmitter x may raise x_ena only while x_busy is 0.
//   In that cycle x_item is captured. x_busy never depends on any x_ena or on req.
// - Output side: out_item moves downstream on every rising edge where
//   out_valid and out_ready are both 1. While out_valid=1 and out_ready=0,
//   out_item and out_valid hold stable.
interface out_arbiter_if #(
    parameter int SIZE = 8
);
    logic [4:0]      req;
    logic            n_ena, s_ena, e_ena, w_ena, l_ena;
    logic [SIZE-1:0] n_item, s_item, e_item, w_item, l_item;
    logic            n_busy, s_busy, e_busy, w_busy, l_busy;
    logic [SIZE-1:0] out_item;
    logic            out_valid;
    logic            out_ready;
    logic            err;

    // Transmitter/sink side of the channel.
    modport master (
        output req,
        output n_ena, s_ena, e_ena, w_ena, l_ena,
        output n_item, s_item, e_item, w_item, l_item,
        output out_ready,
        input  n_busy, s_busy, e_busy, w_busy, l_busy,
        input  out_item, out_valid, err
    );

    // Arbiter side of the channel.
    modport slave (
        input  req,
        input  n_ena, s_ena, e_ena, w_ena, l_ena,
        input  n_item, s_item, e_item, w_item, l_item,
        input  out_ready,
        output n_busy, s_busy, e_busy, w_busy, l_busy,
        output out_item, out_valid, err
    );
endinterface

// File: rtl/out_arbiter.sv
// Round-robin arbiter for one router output port. It owns a grant pointer
// over the N/S/E/W/L transmitters, drives their busy lines, and captures the
// granted flit into a single-entry output register drained by ready/valid.
module out_arbiter #(
    parameter int SIZE = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    out_arbiter_if.slave bus,
    output logic [2:0]   dbg_ptr
);
    typedef enum logic [2:0] {
        PTR_N = 3'd0,
        PTR_S = 3'd1,
        PTR_E = 3'd2,
        PTR_W = 3'd3,
        PTR_L = 3'd4
    } ptr_t;

    ptr_t            ptr, ptr_nxt;
    logic            valid_q, valid_nxt;
    logic [SIZE-1:0] item_q, item_nxt;
    logic            err_q, err_nxt;

    logic [4:0]      ena;
    logic [4:0]      gnt_oh;
    logic [4:0]      busy;
    logic            stall;
    logic            xfer;
    logic [SIZE-1:0] gnt_item;

    assign ena    = {bus.l_ena, bus.w_ena, bus.e_ena, bus.s_ena, bus.n_ena};
    // Pointer values 5..7 decode to no grant, which leaves every line busy.
    assign gnt_oh = 5'b00001 << ptr;
    assign stall  = valid_q & ~bus.out_ready;
    assign busy   = ~gnt_oh | {5{stall}};
    assign xfer   = (|(ena & gnt_oh)) & ~stall;

    assign bus.n_busy    = busy[0];
    assign bus.s_busy    = busy[1];
    assign bus.e_busy    = busy[2];
    assign bus.w_busy    = busy[3];
    assign bus.l_busy    = busy[4];
    assign bus.out_item  = item_q;
    assign bus.out_valid = valid_q;
    assign bus.err       = err_q;
    assign dbg_ptr       = ptr;

    // Select the flit of the current grantee.
    always_comb begin
        gnt_item = bus.n_item;
        case (ptr)
            PTR_S:   gnt_item = bus.s_item;
            PTR_E:   gnt_item = bus.e_item;
            PTR_W:   gnt_item = bus.w_item;
            PTR_L:   gnt_item = bus.l_item;
            default: gnt_item = bus.n_item;
        endcase
    end

    // Next grant, output buffer and error flag.
    always_comb begin
        logic [2:0] base;
        logic       found;
        int         cand;

        ptr_nxt   = ptr;
        valid_nxt = valid_q;
        item_nxt  = item_q;
        err_nxt   = err_q;
        found     = 1'b0;
        cand      = 0;
        // An illegal pointer restarts the search as if it were N.
        base      = (ptr <= PTR_L) ? ptr : PTR_N;

        // Move on after a transfer or when the grantee has nothing pending;
        // the search visits the current grantee last.
        if (xfer || !(|(bus.req & gnt_oh))) begin
            for (int i = 1; i <= 5; i++) begin
                cand = (int'(base) + i) % 5;
                if (!found && bus.req[cand[2:0]]) begin
                    found   = 1'b1;
                    ptr_nxt = ptr_t'(cand[2:0]);
                end
            end
            if (!found) begin
                ptr_nxt = ptr_t'(base);
            end
        end

        // A load wins over a drain so back-to-back flits need no bubble.
        if (xfer) begin
            valid_nxt = 1'b1;
            item_nxt  = gnt_item;
        end else if (valid_q && bus.out_ready) begin
            valid_nxt = 1'b0;
        end

        if (|(ena & busy)) begin
            err_nxt = 1'b1;
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr     <= PTR_N;
            valid_q <= 1'b0;
            item_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            ptr     <= ptr_nxt;
            valid_q <= valid_nxt;
            item_q  <= item_nxt;
            err_q   <= err_nxt;
        end
    end
endmodule

// File: tb/tb_out_arbiter.sv
// Bench for out_arbiter: directed scenarios plus a random phase, with a
// scoreboard queue of flits expected on the output channel.
module tb_out_arbiter;
    localparam int SIZE = 8;

    logic clk;
    logic rst_n;
    logic [2:0] dbg_ptr;

    out_arbiter_if #(.SIZE(SIZE)) bus ();

    out_arbiter #(.SIZE(SIZE)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .dbg_ptr (dbg_ptr)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- stimulus state ----------------
    logic [4:0]      req_v;
    logic [4:0]      ena_v;
    logic [SIZE-1:0] item_v   [5];
    logic [SIZE-1:0] item_cnt [5];
    logic            rdy_v;
    logic [4:0]      busy_seen;
    logic [SIZE-1:0] exp_q [$];
    logic            ord_chk;
    int              ord_exp;
    int              n_checks;
    int              n_errors;

    wire [4:0] busy_v = {bus.l_busy, bus.w_busy, bus.e_busy, bus.s_busy, bus.n_busy};

    assign bus.req       = req_v;
    assign bus.n_ena     = ena_v[0];
    assign bus.s_ena     = ena_v[1];
    assign bus.e_ena     = ena_v[2];
    assign bus.w_ena     = ena_v[3];
    assign bus.l_ena     = ena_v[4];
    assign bus.n_item    = item_v[0];
    assign bus.s_item    = item_v[1];
    assign bus.e_item    = item_v[2];
    assign bus.w_item    = item_v[3];
    assign bus.l_item    = item_v[4];
    assign bus.out_ready = rdy_v;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst_n = 1'b0;
        req_v = '0;
        ena_v = '0;
        rdy_v = 1'b0;
        for (int i = 0; i < 5; i++) item_v[i] = '0;
        exp_q.delete();
        ord_chk = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after a rising edge; returns 1 time unit after the next.
    // 'want' requesters strobe only when not busy; 'bad' requesters strobe
    // regardless (protocol violation, never expected on the output).
    task automatic drive_cycle(input logic [4:0] r, input logic [4:0] want,
                               input logic rdy, input logic [4:0] bad);
        logic [SIZE-1:0] e;
        req_v = r;
        rdy_v = rdy;
        ena_v = '0;
        #1;
        busy_seen = busy_v;
        for (int i = 0; i < 5; i++) begin
            if (bad[i]) begin
                ena_v[i]  = 1'b1;
                item_v[i] = 8'h44;
            end else if (want[i] && !busy_v[i]) begin
                ena_v[i]    = 1'b1;
                item_v[i]   = item_cnt[i];
                exp_q.push_back(item_cnt[i]);
                item_cnt[i] = item_cnt[i] + 1'b1;
            end
        end
        #1;
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_flit", 32'(bus.out_item), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("out_item", 32'(bus.out_item), 32'(e));
                if (ord_chk) begin
                    check("grant_order", 32'(bus.out_item[7:5]), 32'(ord_exp));
                    ord_exp = (ord_exp + 1) % 5;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 10 && (exp_q.size() != 0 || bus.out_valid); k++) begin
            drive_cycle(5'b0, 5'b0, 1'b1, 5'b0);
        end
        check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_drained"}, 32'(bus.out_valid), 32'd0);
    endtask

    // ---------------- scenarios ----------------
    initial begin
        n_checks = 0;
        n_errors = 0;
        ord_exp  = 0;
        for (int i = 0; i < 5; i++) item_cnt[i] = '0;

        // Reset values and single requester E.
        do_reset();
        check("rst_busy", 32'(busy_v), 32'h1E);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_item", 32'(bus.out_item), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_ptr", 32'(dbg_ptr), 32'd0);
        item_cnt[2] = 8'h10;
        drive_cycle(5'b00100, 5'b00100, 1'b1, 5'b0);
        check("e_wait_busy", 32'(busy_seen[2]), 32'd1);
        check("e_ptr", 32'(dbg_ptr), 32'd2);
        check("e_busy_low", 32'(bus.e_busy), 32'd0);
        for (int k = 0; k < 6; k++) begin
            drive_cycle(5'b00100, 5'b00100, 1'b1, 5'b0);
            check("e_streaming", 32'(bus.out_valid), 32'd1);
        end
        check("e_last_item", 32'(bus.out_item), 32'h15);
        drain("e");
        check("e_err", 32'(bus.err), 32'd0);

        // All five requesting: strict N,S,E,W,L rotation.
        do_reset();
        for (int i = 0; i < 5; i++) item_cnt[i] = {i[2:0], 5'h0};
        ord_chk = 1'b1;
        ord_exp = 0;
        for (int k = 0; k < 20; k++) drive_cycle(5'b11111, 5'b11111, 1'b1, 5'b0);
        drain("rr");
        ord_chk = 1'b0;

        // Backpressure: N then E, output stalled after the first flit.
        do_reset();
        item_cnt[0] = 8'h20;
        item_cnt[2] = 8'h21;
        drive_cycle(5'b00101, 5'b00101, 1'b1, 5'b0);
        check("bp_first", 32'(bus.out_item), 32'h20);
        for (int k = 0; k < 3; k++) begin
            drive_cycle(5'b00101, 5'b00101, 1'b0, 5'b0);
            check("bp_all_busy", 32'(busy_seen), 32'h1F);
            check("bp_hold_item", 32'(bus.out_item), 32'h20);
            check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
        end
        drive_cycle(5'b00101, 5'b00100, 1'b1, 5'b0);
        check("bp_e_granted", 32'(busy_seen), 32'h1B);
        check("bp_e_lands", 32'(bus.out_item), 32'h21);
        drain("bp");

        // Simultaneous drain and load with no bubble.
        do_reset();
        item_cnt[0] = 8'h32;
        drive_cycle(5'b00001, 5'b00001, 1'b1, 5'b0);
        drive_cycle(5'b00001, 5'b00001, 1'b1, 5'b0);
        check("dl_valid", 32'(bus.out_valid), 32'd1);
        check("dl_item", 32'(bus.out_item), 32'h33);
        drain("dl");

        // Protocol violation: W strobes while N holds the grant.
        do_reset();
        drive_cycle(5'b00000, 5'b00000, 1'b1, 5'b01000);
        check("viol_err", 32'(bus.err), 32'd1);
        check("viol_not_captured", 32'(bus.out_item == 8'h44), 32'd0);
        check("viol_no_valid", 32'(bus.out_valid), 32'd0);
        check("viol_ptr", 32'(dbg_ptr), 32'd0);
        repeat (3) drive_cycle(5'b00000, 5'b00000, 1'b1, 5'b0);
        check("viol_sticky", 32'(bus.err), 32'd1);
        do_reset();
        check("viol_cleared", 32'(bus.err), 32'd0);

        // Reset mid-stream with a buffered W flit.
        item_cnt[3] = 8'h55;
        drive_cycle(5'b01000, 5'b01000, 1'b0, 5'b0);
        drive_cycle(5'b01000, 5'b01000, 1'b0, 5'b0);
        check("mid_ptr_w", 32'(dbg_ptr), 32'd3);
        check("mid_valid", 32'(bus.out_valid), 32'd1);
        check("mid_item", 32'(bus.out_item), 32'h55);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_item", 32'(bus.out_item), 32'd0);
        check("mid_rst_busy", 32'(busy_v), 32'h1E);
        check("mid_rst_ptr", 32'(dbg_ptr), 32'd0);
        do_reset();

        // Random traffic: legal strobes, random requests and backpressure.
        for (int i = 0; i < 5; i++) item_cnt[i] = SIZE'($urandom_range(0, 255));
        for (int k = 0; k < 400; k++) begin
            logic [4:0] r;
            logic [4:0] w;
            r = 5'($urandom_range(0, 31));
            w = r | 5'($urandom_range(0, 31) & $urandom_range(0, 31));
            drive_cycle(r, w, ($urandom_range(0, 3) != 0), 5'b0);
        end
        drain("rnd");
        check("rnd_err", 32'(bus.err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
